rvfi_retire_serializer: RTL and testbench

//  Multi-wide successor to the single-commit RVFI glue in the mp4 testbench top.

---
 rtl/rvfi_pkg.sv | 25 ++
 rtl/rvfi_mw_fifo.sv | 65 ++++++
 rtl/rvfi_retire_serializer.sv | 98 +++++++++
 tb/tb_rvfi_retire_serializer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rvfi_pkg.sv
// Shared RVFI retire packet type and halt constant.
// Used by rvfi_mw_fifo and rvfi_retire_serializer (optional feature macro: RVFI_PC_CHECK_EN).
package rvfi_pkg;

    localparam logic [31:0] RVFI_HALT_DEFAULT = 32'h0007d463;

    typedef struct packed {
        logic [31:0] inst;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [31:0] rs1_rdata;
        logic [31:0] rs2_rdata;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
        logic        load_regfile;
        logic [31:0] pc_rdata;
        logic [31:0] pc_wdata;
        logic [31:0] mem_addr;
        logic [3:0]  mem_rmask;
        logic [3:0]  mem_wmask;
        logic [31:0] mem_rdata;
        logic [31:0] mem_wdata;
    } pkt_t;

endpackage

// File: rtl/rvfi_mw_fifo.sv
// COMMIT_W-write / 1-read circular buffer. Valid write slots are compacted
// into consecutive tail positions in ascending slot order.
module rvfi_mw_fifo
    import rvfi_pkg::*;
#(
    parameter int COMMIT_W = 2,
    parameter int DEPTH    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [COMMIT_W-1:0]       wr_valid,
    input  pkt_t [COMMIT_W-1:0]       wr_pkt,
    input  logic                      rd_en,
    output pkt_t                      rd_pkt,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    pkt_t             mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] wr_cnt;
    logic [PTR_W-1:0] wr_idx [COMMIT_W];

    // Each valid slot lands at tail + (number of valid slots below it).
    always_comb begin
        wr_cnt = '0;
        for (int i = 0; i < COMMIT_W; i++) begin
            wr_idx[i] = tail + wr_cnt[PTR_W-1:0];
            wr_cnt    = wr_cnt + CNT_W'(wr_valid[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < COMMIT_W; i++) begin
                if (wr_valid[i]) begin
                    mem[wr_idx[i]] <= wr_pkt[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (wr_en) begin
                tail <= tail + wr_cnt[PTR_W-1:0];
            end
            if (rd_en) begin
                head <= head + PTR_W'(1);
            end
            count <= count + (wr_en ? wr_cnt : CNT_W'(0)) - CNT_W'(rd_en);
        end
    end

    assign rd_pkt = (count != '0) ? mem[head] : '0;

endmodule

// File: rtl/rvfi_retire_serializer.sv
// Serializes multi-wide ROB retire groups into one RVFI packet per cycle,
// stamping order numbers and detecting halt. Optional macro: RVFI_PC_CHECK_EN.
module rvfi_retire_serializer
    import rvfi_pkg::*;
#(
    parameter int          COMMIT_W  = 2,
    parameter int          DEPTH     = 16,
    parameter logic [31:0] HALT_INST = RVFI_HALT_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [COMMIT_W-1:0]    in_valid,
    input  pkt_t [COMMIT_W-1:0]    in_pkt,
    output logic                   in_ready,
    input  logic                   out_ready,
    output logic                   out_valid,
    output pkt_t                   out_pkt,
    output logic [63:0]            out_order,
    output logic                   out_halt,
    output logic                   halted,
    output logic [$clog2(DEPTH):0] occupancy,
    output logic                   proto_err
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic any_valid;
    logic gap;
    logic enq;
    logic pop;
    logic enq_err;
    logic pc_err;

    // Handshake: a group is taken when any slot is valid and in_ready is high;
    // a packet is consumed when out_valid and out_ready are both high.
    assign any_valid = |in_valid;
    assign in_ready  = (occupancy <= CNT_W'(DEPTH - COMMIT_W)) && !halted;
    assign enq       = any_valid && in_ready;
    // Valid slots must form a run starting at slot 0.
    assign gap       = (in_valid & (in_valid + COMMIT_W'(1))) != '0;
    assign enq_err   = any_valid && (!in_ready || gap);

    assign out_valid = (occupancy != '0);
    assign pop       = out_valid && out_ready;
    assign out_halt  = out_valid && (out_pkt.inst == HALT_INST);

    rvfi_mw_fifo #(
        .COMMIT_W (COMMIT_W),
        .DEPTH    (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (enq),
        .wr_valid (in_valid),
        .wr_pkt   (in_pkt),
        .rd_en    (pop),
        .rd_pkt   (out_pkt),
        .count    (occupancy)
    );

`ifdef RVFI_PC_CHECK_EN
    logic [31:0] prev_pc_wdata;
    logic        prev_pc_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_pc_wdata <= '0;
            prev_pc_valid <= 1'b0;
        end else if (pop) begin
            prev_pc_wdata <= out_pkt.pc_wdata;
            prev_pc_valid <= 1'b1;
        end
    end

    assign pc_err = pop && prev_pc_valid && (out_pkt.pc_rdata != prev_pc_wdata);
`else
    assign pc_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            out_order <= '0;
            halted    <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            if (pop) begin
                out_order <= out_order + 64'd1;
            end
            if (pop && out_halt) begin
                halted <= 1'b1;
            end
            if (enq_err || pc_err) begin
                proto_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rvfi_retire_serializer.sv
// Scoreboard bench for rvfi_retire_serializer: queue-based reference model,
// directed retire patterns plus randomized traffic.
module tb_rvfi_retire_serializer;
    import rvfi_pkg::*;

    localparam int          COMMIT_W = 2;
    localparam int          DEPTH    = 16;
    localparam logic [31:0] HALT     = 32'h0007d463;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [COMMIT_W-1:0]   in_valid = '0;
    pkt_t [COMMIT_W-1:0]   in_pkt = '0;
    logic                  in_ready;
    logic                  out_ready = 1'b0;
    logic                  out_valid;
    pkt_t                  out_pkt;
    logic [63:0]           out_order;
    logic                  out_halt;
    logic                  halted;
    logic [$clog2(DEPTH):0] occupancy;
    logic                  proto_err;

    rvfi_retire_serializer #(
        .COMMIT_W  (COMMIT_W),
        .DEPTH     (DEPTH),
        .HALT_INST (HALT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_pkt    (in_pkt),
        .in_ready  (in_ready),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_pkt   (out_pkt),
        .out_order (out_order),
        .out_halt  (out_halt),
        .halted    (halted),
        .occupancy (occupancy),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    // Reference model state
    pkt_t        exp_q[$];
    logic [63:0] m_order = '0;
    bit          m_halted = 0;
    bit          m_err = 0;
    bit          m_prev_valid = 0;
    logic [31:0] m_prev_pc = '0;
    logic [31:0] pc_ctr = 32'h60;
    bit          pc_jump = 0;
    bit          mon_en = 0;

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, want, $time);
        end
    endtask

    function automatic pkt_t rand_pkt();
        pkt_t p;
        p.inst         = $urandom;
        if (p.inst == HALT) p.inst = p.inst ^ 32'h1;
        p.rs1_addr     = 5'($urandom);
        p.rs2_addr     = 5'($urandom);
        p.rs1_rdata    = $urandom;
        p.rs2_rdata    = $urandom;
        p.rd_addr      = 5'($urandom);
        p.rd_wdata     = $urandom;
        p.load_regfile = 1'($urandom);
        p.pc_rdata     = $urandom;
        p.pc_wdata     = $urandom;
        p.mem_addr     = $urandom;
        p.mem_rmask    = 4'($urandom);
        p.mem_wmask    = 4'($urandom);
        p.mem_rdata    = $urandom;
        p.mem_wdata    = $urandom;
        return p;
    endfunction

    // Driver: one cycle of stimulus; the model's expectation is committed at the clock edge.
    task automatic drive_cycle(input logic [1:0] v, input logic rdy, input logic [31:0] inst0);
        pkt_t p [2];
        bit   acc;
        bit   err;
        bit   placed;
        @(negedge clk);
        placed = 0;
        for (int i = 0; i < COMMIT_W; i++) begin
            p[i] = rand_pkt();
            if (v[i]) begin
                if (pc_jump) begin
                    pc_ctr  = pc_ctr + 32'd4;
                    pc_jump = 0;
                end
                p[i].pc_rdata = pc_ctr;
                p[i].pc_wdata = pc_ctr + 32'd4;
                pc_ctr        = pc_ctr + 32'd4;
                if (!placed && inst0 != 32'd0) begin
                    p[i].inst = inst0;
                    placed    = 1;
                end
            end
        end
        in_valid  = v;
        in_pkt[0] = p[0];
        in_pkt[1] = p[1];
        out_ready = rdy;
        acc = (v != 2'b00) && (DEPTH - exp_q.size() >= COMMIT_W) && !m_halted;
        err = (v != 2'b00) && (!acc || v == 2'b10);
        @(posedge clk);
        if (acc) begin
            for (int i = 0; i < COMMIT_W; i++) begin
                if (v[i]) exp_q.push_back(p[i]);
            end
        end
        if (err) m_err = 1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        mon_en    = 0;
        rst       = 1'b1;
        in_valid  = '0;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        m_order      = '0;
        m_halted     = 0;
        m_err        = 0;
        m_prev_valid = 0;
        mon_en       = 1;
    endtask

    // Monitor: compares DUT outputs against the model, pops on each handshake.
    initial begin
        pkt_t h;
        forever begin
            @(negedge clk);
            #1;
            if (mon_en) begin
                check("occupancy", occupancy, exp_q.size());
                check("in_ready", in_ready, (DEPTH - exp_q.size() >= COMMIT_W) && !m_halted);
                check("out_valid", out_valid, exp_q.size() != 0);
                check("out_order", out_order, m_order);
                check("halted", halted, m_halted);
                check("proto_err", proto_err, m_err);
                if (exp_q.size() == 0) begin
                    check("out_pkt_zero", out_pkt == '0, 1'b1);
                    check("out_halt_idle", out_halt, 1'b0);
                end else begin
                    h = exp_q[0];
                    check("out_inst", out_pkt.inst, h.inst);
                    check("out_pc", out_pkt.pc_rdata, h.pc_rdata);
                    check("out_pkt", out_pkt == h, 1'b1);
                    check("out_halt", out_halt, h.inst == HALT);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        m_order = m_order + 64'd1;
                        if (h.inst == HALT) m_halted = 1;
`ifdef RVFI_PC_CHECK_EN
                        if (m_prev_valid && h.pc_rdata != m_prev_pc) m_err = 1;
                        m_prev_pc    = h.pc_wdata;
                        m_prev_valid = 1;
`endif
                    end
                end
            end
        end
    end

    initial begin
        logic [1:0] v;
        int r;

        do_reset();

        // Two-wide retire, drained one per cycle
        pc_ctr = 32'h60;
        drive_cycle(2'b11, 1'b1, 32'd0);
        for (int i = 0; i < 3; i++) drive_cycle(2'b00, 1'b1, 32'd0);

        // Fill with no consumer until overflow is flagged
        do_reset();
        for (int i = 0; i < 10; i++) drive_cycle(2'b11, 1'b0, 32'd0);
        for (int i = 0; i < 18; i++) drive_cycle(2'b00, 1'b1, 32'd0);

        // Steady 1-in/1-out across pointer wrap
        do_reset();
        for (int i = 0; i < 40; i++) drive_cycle(2'b01, 1'b1, 32'd0);
        drive_cycle(2'b00, 1'b1, 32'd0);

        // Non-contiguous retire valid
        do_reset();
        drive_cycle(2'b10, 1'b0, 32'd0);
        drive_cycle(2'b00, 1'b1, 32'd0);
        drive_cycle(2'b00, 1'b1, 32'd0);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 9);
            v = (r < 2) ? 2'b00 : (r < 5) ? 2'b01 : (r < 9) ? 2'b11 : 2'b10;
            drive_cycle(v, 1'($urandom_range(0, 2) != 0), 32'd0);
        end
        for (int i = 0; i < 20; i++) drive_cycle(2'b00, 1'b1, 32'd0);

        // Halt followed by two trailing instructions
        do_reset();
        drive_cycle(2'b01, 1'b0, 32'd0);
        drive_cycle(2'b11, 1'b0, HALT);
        drive_cycle(2'b01, 1'b0, 32'd0);
        for (int i = 0; i < 6; i++) drive_cycle(2'b00, 1'b1, 32'd0);
        drive_cycle(2'b11, 1'b1, 32'd0);
        drive_cycle(2'b00, 1'b1, 32'd0);

        // PC discontinuity: pc_wdata 0x64 followed by pc_rdata 0x68
        do_reset();
        pc_ctr = 32'h60;
        drive_cycle(2'b01, 1'b1, 32'd0);
        pc_jump = 1;
        drive_cycle(2'b01, 1'b1, 32'd0);
        for (int i = 0; i < 3; i++) drive_cycle(2'b00, 1'b1, 32'd0);

        // Mid-stream reset discards buffered entries and order
        do_reset();
        for (int i = 0; i < 4; i++) drive_cycle(2'b11, 1'b1, 32'd0);
        drive_cycle(2'b11, 1'b0, 32'd0);
        do_reset();
        drive_cycle(2'b00, 1'b1, 32'd0);
        drive_cycle(2'b01, 1'b1, 32'd0);
        drive_cycle(2'b00, 1'b1, 32'd0);
        drive_cycle(2'b00, 1'b1, 32'd0);

        mon_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
